led_to_bcd_scanner: RTL and testbench

Reconstructs up to four displayed digits by watching a multiplexed, active-low 7-segment bus (seg/an), as driven by the board's display path. For each one-hot-low anode strobe, it waits until seg/an have been stable, decodes the segment pattern back to a 4-bit value, and stores it per digit. It pulses a frame flag once all four digits have been captured. It sits beside the display driver as a self-check/readback block, and is the decoding end of the BCD-to-LED encoding.

---
 rtl/led_to_bcd_pkg.sv | 29 ++
 rtl/seg7_pattern_decode.sv | 37 +++
 rtl/led_to_bcd_scanner.sv | 108 ++++++++++
 tb/tb_led_to_bcd_scanner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/led_to_bcd_pkg.sv
// Shared constants for the 7-segment readback path: active-low segment
// patterns for 0-F, scanner state encoding and digit count.
package led_to_bcd_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic {
    SETTLING = 1'b0,
    HOLD     = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low 7-segment pattern to nibble decode, zero latency, no backpressure.
// A-F decode only when LED_TO_BCD_HEX_EN is defined; otherwise they report invalid.
module seg7_pattern_decode
  import led_to_bcd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] value
);

  always_comb begin
    valid = 1'b1;
    value = 4'h0;
    case (seg)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
`ifdef LED_TO_BCD_HEX_EN
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
`endif
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_to_bcd_scanner.sv
// Reads back a multiplexed active-low 7-seg bus into four digits; capture STABLE_CYCLES edges after the last change.
// No backpressure (passive observer); LED_TO_BCD_HEX_EN enables A-F decode.
module led_to_bcd_scanner
  import led_to_bcd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid
);

  localparam logic [8:0] STABLE_TGT = 9'(STABLE_CYCLES);

  logic [10:0]           sample_q;
  logic [7:0]            cnt;
  state_t                state, state_nxt;
  logic [NUM_DIGITS-1:0] mask;

  logic                  changed;
  logic                  stable_hit;
  logic                  strobe_ok;
  logic [1:0]            strobe_idx;
  logic [NUM_DIGITS-1:0] strobe_sel;
  logic                  capture;
  logic                  dec_valid;
  logic [3:0]            dec_value;

  seg7_pattern_decode u_decode (
    .seg   (seg),
    .valid (dec_valid),
    .value (dec_value)
  );

  assign changed = ({an, seg} != sample_q);
  // cnt counts stable edges already seen, so this edge is number cnt+1
  assign stable_hit = (state == SETTLING) && !changed &&
                      (({1'b0, cnt} + 9'd1) >= STABLE_TGT);

  always_comb begin
    strobe_ok  = 1'b1;
    strobe_idx = 2'd0;
    case (an)
      4'b1110: strobe_idx = 2'd0;
      4'b1101: strobe_idx = 2'd1;
      4'b1011: strobe_idx = 2'd2;
      4'b0111: strobe_idx = 2'd3;
      default: strobe_ok  = 1'b0;
    endcase
  end

  assign strobe_sel = ~an;
  assign capture    = stable_hit && strobe_ok;

  always_comb begin
    state_nxt = state;
    if (changed) begin
      state_nxt = SETTLING;
    end else if (stable_hit) begin
      state_nxt = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SETTLING;
      sample_q <= '1;
      cnt      <= 8'd0;
    end else begin
      state <= state_nxt;
      if (changed) begin
        sample_q <= {an, seg};
        cnt      <= 8'd0;
      end else if (state == SETTLING && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_err   <= '0;
      mask        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (capture) begin
        if (dec_valid) begin
          digits[{strobe_idx, 2'b00} +: 4] <= dec_value;
        end
        digit_err[strobe_idx] <= ~dec_valid;
        // frame completes on the capture that fills the last mask bit
        if ((mask | strobe_sel) == '1) begin
          frame_valid <= 1'b1;
          mask        <= '0;
        end else begin
          mask <= mask | strobe_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_to_bcd_scanner.sv
// Directed bench for led_to_bcd_scanner with a run-length reference model checked every cycle.
module tb_led_to_bcd_scanner;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;

  int tests = 0;
  int fails = 0;
  int fv_cnt = 0;
  bit cmp_en = 1'b0;
  bit glitch_win = 1'b0;
  bit saw_zero = 1'b0;

  led_to_bcd_scanner #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef LED_TO_BCD_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  // Reference: a value is captured when it has been seen on exactly S
  // consecutive edges after the edge where it first appeared.
  logic [10:0] m_last;
  int          m_run;
  logic [15:0] m_dig;
  logic [3:0]  m_err;
  logic [3:0]  m_mask;
  logic        m_fv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 11'h7FF;
      m_run  = 0;
      m_dig  = '0;
      m_err  = '0;
      m_mask = '0;
      m_fv   = 1'b0;
    end else begin
      m_fv = 1'b0;
      if ({an, seg} != m_last) begin
        m_last = {an, seg};
        m_run  = 0;
      end else begin
        m_run = m_run + 1;
        if (m_run == S && $countones(~an) == 1) begin
          int  idx;
          int  val;
          idx = 0;
          val = -1;
          for (int k = 0; k < 4; k++) if (!an[k]) idx = k;
          for (int k = 0; k < 16; k++) if (pat[k] == seg && (k < 10 || HEX)) val = k;
          if (val >= 0) begin
            m_dig[idx*4 +: 4] = 4'(val);
            m_err[idx] = 1'b0;
          end else begin
            m_err[idx] = 1'b1;
          end
          m_mask[idx] = 1'b1;
          if (m_mask == 4'hF) begin
            m_fv   = 1'b1;
            m_mask = 4'h0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (glitch_win && digits[3:0] == 4'h0) saw_zero = 1'b1;
    if (cmp_en) begin
      chk("model_digits", 32'(digits), 32'(m_dig));
      chk("model_err", 32'(digit_err), 32'(m_err));
      chk("model_frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("model_mask", 32'(dut.mask), 32'(m_mask));
    end
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int fv0;
    logic [15:0] dsnap;
    @(negedge clk);
    cmp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      an  = 4'($urandom);
      seg = 7'($urandom);
      @(negedge clk);
    end
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_err", 32'(digit_err), 32'h0);
    chk("reset_fv", 32'(frame_valid), 32'h0);

    an = 4'hF; seg = 7'h7F;
    rst_n = 1'b1;
    hold(4'hF, 7'h7F, 20);
    chk("blank_digits", 32'(digits), 32'h0);
    chk("blank_no_pulse", 32'(fv_cnt), 32'd0);

    hold(4'hE, 7'h79, 6);
    hold(4'hD, 7'h24, 6);
    hold(4'hB, 7'h30, 6);
    hold(4'h7, 7'h19, 6);
    chk("frame_digits", 32'(digits), 32'h4321);
    chk("frame_err", 32'(digit_err), 32'h0);
    chk("frame_one_pulse", 32'(fv_cnt), 32'd1);

    hold(4'hE, 7'h12, 6);
    chk("digit0_five", 32'(digits), 32'h4325);
    glitch_win = 1'b1;
    hold(4'hE, 7'h40, 3);
    hold(4'hE, 7'h79, 6);
    glitch_win = 1'b0;
    chk("glitch_digit0", 32'(digits[3:0]), 32'h1);
    chk("glitch_never_zero", 32'(saw_zero), 32'h0);

    hold(4'hE, 7'h08, 6);
    chk("hex_digit0", 32'(digits[3:0]), HEX ? 32'hA : 32'h1);
    chk("hex_err0", 32'(digit_err[0]), HEX ? 32'h0 : 32'h1);
    hold(4'hE, 7'h40, 6);
    chk("hex_err_clear", 32'(digit_err[0]), 32'h0);
    chk("hex_then_zero", 32'(digits[3:0]), 32'h0);

    hold(4'hD, 7'h00, 4);
    chk("short_hold_no_cap", 32'(digits[7:4]), 32'h2);
    hold(4'hF, 7'h7F, 1);
    hold(4'hD, 7'h00, 5);
    chk("min_hold_cap", 32'(digits[7:4]), 32'h8);

    fv0 = fv_cnt;
    dsnap = digits;
    hold(4'hC, 7'h00, 10);
    hold(4'hF, 7'h00, 10);
    chk("bad_strobe_digits", 32'(digits), 32'(dsnap));
    chk("bad_strobe_literal", 32'(digits), 32'h4380);
    chk("bad_strobe_mask", 32'(dut.mask), 32'h3);
    chk("bad_strobe_no_pulse", 32'(fv_cnt), 32'(fv0));

    hold(4'hE, 7'h78, 6);
    hold(4'hD, 7'h00, 6);
    hold(4'hB, 7'h10, 6);
    chk("partial_digits", 32'(digits), 32'h4987);
    chk("partial_no_pulse", 32'(fv_cnt), 32'(fv0));
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_digits", 32'(digits), 32'h0);
    hold(4'h7, 7'h02, 6);
    chk("after_reset_digits", 32'(digits), 32'h6000);
    chk("after_reset_no_pulse", 32'(fv_cnt), 32'(fv0));
    chk("after_reset_mask", 32'(dut.mask), 32'h8);
    hold(4'hF, 7'h7F, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
